// File: rtl/register_bank.sv
// register_bank
//   MIPS-style register file with two combinational read ports and one write
//   port (write-first forwarding), register 0 hardwired to zero, a
//   synchronised user-input register, a registered display mirror and a
//   handshaked scan engine that streams every register out, one beat each.
//
// Ports
//   clock, reset                 : rising-edge clock, async active-high reset
//   readRegister1/2, readData1/2 : combinational read ports
//   writeRegister, RegWrite,
//   writeData                    : write port
//   user_number                  : asynchronous switches -> regfile[INPUT_REG]
//   toDisplay                    : registered copy of regfile[DISPLAY_REG]
//   scan_start                   : request a full dump (honoured in IDLE only)
//   scan_ready                   : consumer accepts the current beat
//   scan_valid, scan_index,
//   scan_data, scan_busy         : scan beat outputs and status
module register_bank #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int USER_WIDTH  = 6,
    parameter int INPUT_REG   = 30,
    parameter int DISPLAY_REG = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic                  RegWrite,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    input  logic [USER_WIDTH-1:0] user_number,
    output logic [DATA_WIDTH-1:0] toDisplay,
    input  logic                  scan_start,
    input  logic                  scan_ready,
    output logic                  scan_valid,
    output logic [ADDR_WIDTH-1:0] scan_index,
    output logic [DATA_WIDTH-1:0] scan_data,
    output logic                  scan_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IN_IDX   = ADDR_WIDTH'(INPUT_REG);
    localparam logic [ADDR_WIDTH-1:0] DISP_IDX = ADDR_WIDTH'(DISPLAY_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    logic [DATA_WIDTH-1:0] regfile_q [DEPTH];
    logic [USER_WIDTH-1:0] sync1_q, sync2_q;
    logic [DATA_WIDTH-1:0] toDisplay_q, toDisplay_d;
    logic [DATA_WIDTH-1:0] user_ext;
    logic                  wr_en;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] scan_index_q, scan_index_d;
    logic [DATA_WIDTH-1:0] scan_data_q, scan_data_d;

    // The input register is owned by the synchroniser, so CPU writes to it
    // are dropped along with writes to register 0.
    assign wr_en    = RegWrite && (writeRegister != '0) && (writeRegister != IN_IDX);
    assign user_ext = DATA_WIDTH'(sync2_q);

    // Forwarding also covers the wr_en exclusions: no bypass for r0 or INPUT_REG.
    always_comb begin
        readData1 = regfile_q[readRegister1];
        if (readRegister1 == '0)
            readData1 = '0;
        else if (wr_en && readRegister1 == writeRegister)
            readData1 = writeData;
    end

    always_comb begin
        readData2 = regfile_q[readRegister2];
        if (readRegister2 == '0)
            readData2 = '0;
        else if (wr_en && readRegister2 == writeRegister)
            readData2 = writeData;
    end

    // Display tracks the register's next-state so it never lags the file.
    assign toDisplay_d = (wr_en && writeRegister == DISP_IDX) ? writeData
                                                              : regfile_q[DISP_IDX];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regfile_q[i] <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            toDisplay_q <= '0;
        end else begin
            sync1_q     <= user_number;
            sync2_q     <= sync1_q;
            toDisplay_q <= toDisplay_d;
            if (wr_en) regfile_q[writeRegister] <= writeData;
            regfile_q[IN_IDX] <= user_ext;
        end
    end

    assign toDisplay  = toDisplay_q;
    assign scan_index = scan_index_q;
    assign scan_data  = scan_data_q;

    // Scan engine. LOAD samples the stored value (pre-write), SEND holds the
    // beat until accepted. idx stops at the last address instead of wrapping.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scan_index_d = scan_index_q;
        scan_data_d  = scan_data_q;
        scan_valid   = 1'b0;
        scan_busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                scan_busy    = 1'b1;
                scan_data_d  = regfile_q[idx_q];
                scan_index_d = idx_q;
                state_d      = S_SEND;
            end
            S_SEND: begin
                scan_busy  = 1'b1;
                scan_valid = 1'b1;
                if (scan_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            scan_index_q <= '0;
            scan_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scan_index_q <= scan_index_d;
            scan_data_q  <= scan_data_d;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Testbench for register_bank: directed steps plus randomized traffic,
// checked against an array/queue model of the register file.
module tb_register_bank;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int UW = 6;
    localparam int DEPTH = 32;
    localparam logic [AW-1:0] IN_A   = 5'd30;
    localparam logic [AW-1:0] DISP_A = 5'd31;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] readRegister1, readRegister2, writeRegister;
    logic          RegWrite;
    logic [DW-1:0] writeData, readData1, readData2, toDisplay, scan_data;
    logic [UW-1:0] user_number;
    logic          scan_start, scan_ready, scan_valid, scan_busy;
    logic [AW-1:0] scan_index;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] model [DEPTH];
    logic [UW-1:0] hist [$];   // user_number sampled at each edge

    register_bank dut (
        .clock(clock), .reset(reset),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .writeRegister(writeRegister), .RegWrite(RegWrite), .writeData(writeData),
        .readData1(readData1), .readData2(readData2),
        .user_number(user_number), .toDisplay(toDisplay),
        .scan_start(scan_start), .scan_ready(scan_ready),
        .scan_valid(scan_valid), .scan_index(scan_index),
        .scan_data(scan_data), .scan_busy(scan_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit cpu_write_ok();
        return RegWrite && writeRegister != 0 && writeRegister != IN_A;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (cpu_write_ok() && writeRegister == a) return writeData;
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        hist.delete();
    endtask

    // Advance one edge, updating the model from the inputs applied before it.
    // The input register shows the switch value sampled two edges earlier.
    task automatic tick();
        if (cpu_write_ok()) model[writeRegister] = writeData;
        hist.push_back(user_number);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() >= 3) model[IN_A] = DW'(hist[hist.size() - 3]);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reads(input string tag);
        chk({tag, "_rd1"}, readData1, exp_read(readRegister1));
        chk({tag, "_rd2"}, readData2, exp_read(readRegister2));
    endtask

    task automatic run_scan(input bit rnd, input int rst_beat);
        int beats = 0;
        int cyc = 0;
        bit done = 0;
        bit held = 0;
        logic [AW-1:0] hidx;
        logic [DW-1:0] hdat;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        chk("scan_load_busy", 32'(scan_busy), 32'd1);
        chk("scan_load_valid", 32'(scan_valid), 32'd0);
        while (!done && cyc < 400) begin
            if (rst_beat >= 0 && beats == rst_beat) begin
                reset = 1'b1;
                #1;
                chk("rst_valid", 32'(scan_valid), 32'd0);
                chk("rst_busy", 32'(scan_busy), 32'd0);
                chk("rst_index", 32'(scan_index), 32'd0);
                chk("rst_data", scan_data, 32'd0);
                chk("rst_disp", toDisplay, 32'd0);
                readRegister1 = IN_A;
                readRegister2 = 5'd5;
                #1;
                chk("rst_r30", readData1, 32'd0);
                chk("rst_r5", readData2, 32'd0);
                reset = 1'b0;
                model_reset();
                done = 1;
            end else begin
                scan_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!rnd) chk("scan_cadence", 32'(scan_valid), 32'(cyc % 2));
                if (held) begin
                    chk("hold_valid", 32'(scan_valid), 32'd1);
                    chk("hold_index", 32'(scan_index), 32'(hidx));
                    chk("hold_data", scan_data, hdat);
                end
                held = 0;
                if (scan_valid) begin
                    if (scan_ready) begin
                        chk("beat_index", 32'(scan_index), 32'(beats));
                        chk("beat_data", scan_data, model[beats]);
                        beats++;
                    end else begin
                        held = 1;
                        hidx = scan_index;
                        hdat = scan_data;
                    end
                end
                tick();
                cyc++;
                if (!scan_busy) done = 1;
            end
        end
        chk("scan_no_timeout", 32'(done), 32'd1);
        if (rst_beat < 0) chk("scan_beats", 32'(beats), 32'(DEPTH));
        if (rst_beat < 0 && !rnd) chk("scan_cycles", 32'(cyc), 32'(2 * DEPTH));
        scan_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        readRegister1 = '0; readRegister2 = '0; writeRegister = '0;
        RegWrite = 1'b0; writeData = '0; user_number = '0;
        scan_start = 1'b0; scan_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;

        // Reset state: every register reads zero on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            readRegister1 = AW'(i);
            readRegister2 = AW'(DEPTH - 1 - i);
            #1;
            chk("reset_rd1", readData1, 32'd0);
            chk("reset_rd2", readData2, 32'd0);
        end
        chk("reset_disp", toDisplay, 32'd0);
        chk("reset_valid", 32'(scan_valid), 32'd0);
        chk("reset_busy", 32'(scan_busy), 32'd0);
        reset = 1'b0;
        tick();

        // Same-cycle forwarding, then the stored value.
        RegWrite = 1'b1; writeRegister = 5'd5; writeData = 32'hDEADBEEF; readRegister1 = 5'd5;
        #1;
        chk("fwd_r5", readData1, 32'hDEADBEEF);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("stored_r5", readData1, 32'hDEADBEEF);

        // Register 0: no forwarding, no store.
        RegWrite = 1'b1; writeRegister = 5'd0; writeData = 32'h1234; readRegister1 = 5'd0;
        #1;
        chk("r0_fwd", readData1, 32'd0);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r0_stored", readData1, 32'd0);

        // Input register: 3-edge latency, CPU writes ignored.
        user_number = 6'h2A; readRegister1 = IN_A;
        tick(); tick();
        chk("user_lat2", readData1, 32'd0);
        tick();
        chk("user_lat3", readData1, 32'h2A);
        RegWrite = 1'b1; writeRegister = IN_A; writeData = 32'hFFFF; readRegister2 = IN_A;
        #1;
        chk("r30_nofwd", readData2, 32'h2A);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r30_kept", readData2, 32'h2A);

        // Display mirror.
        RegWrite = 1'b1; writeRegister = DISP_A; writeData = 32'h7;
        tick();
        RegWrite = 1'b0;
        chk("disp_7", toDisplay, 32'h7);

        // Randomized read/write traffic.
        for (int n = 0; n < 300; n++) begin
            RegWrite      = 1'($urandom_range(0, 1));
            writeRegister = AW'($urandom_range(0, DEPTH - 1));
            writeData     = $urandom;
            readRegister1 = ($urandom_range(0, 3) == 0) ? writeRegister : AW'($urandom_range(0, DEPTH - 1));
            readRegister2 = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 19) == 0) user_number = UW'($urandom);
            #1;
            chk_reads("rand");
            tick();
            chk("rand_disp", toDisplay, model[DISP_A]);
        end
        RegWrite = 1'b0;

        // Preload r_i = i*0x11 with the input register showing 0x2A.
        user_number = 6'h2A;
        for (int i = 0; i < DEPTH; i++) begin
            RegWrite = 1'b1; writeRegister = AW'(i); writeData = 32'(i * 32'h11);
            tick();
        end
        RegWrite = 1'b0;
        tick(); tick(); tick();
        readRegister1 = IN_A; readRegister2 = 5'd17;
        #1;
        chk("pre_r30", readData1, 32'h2A);
        chk("pre_r17", readData2, 32'(17 * 32'h11));

        // Full scan, ready held high.
        run_scan(1'b0, -1);
        chk("scan_idle_busy", 32'(scan_busy), 32'd0);

        // Scan with random ready, reset at beat 10.
        run_scan(1'b1, 10);
        tick();
        chk("post_rst_busy", 32'(scan_busy), 32'd0);

        // Recovery: scan with random ready over the cleared file.
        repeat (4) tick();
        run_scan(1'b1, -1);
        chk("final_busy", 32'(scan_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
